// File: rtl/acdc_pkg.sv
// Shared types and defaults for the ACDC host-side run sequencer.
// The run-cycle timeout is built only when RUN_CTRL_TIMEOUT_EN is defined.
package acdc_pkg;

    localparam int AW_DEF           = 8;
    localparam int DW_DEF           = 8;
    localparam int CW_DEF           = 16;
    localparam int START_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        RS_IDLE  = 3'd0,
        RS_LOAD  = 3'd1,
        RS_START = 3'd2,
        RS_RUN   = 3'd3,
        RS_DONE  = 3'd4,
        RS_TMO   = 3'd5
    } run_state_t;

    // States in which a go request launches a new run.
    function automatic logic accepts_go(input run_state_t st);
        return (st == RS_IDLE) || (st == RS_DONE) || (st == RS_TMO);
    endfunction

endpackage

// File: rtl/run_counter.sv
// CW-bit run-cycle counter with synchronous clear, enable, saturation at all-ones
// and an equality compare against a fixed limit.
module run_counter #(
    parameter int            CW    = 16,
    parameter logic [CW-1:0] LIMIT = {CW{1'b1}}
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_at_limit
);

    logic [CW-1:0] r_count;

    // Count enabled cycles; never wrap past all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= {CW{1'b0}};
        end else if (i_clr) begin
            r_count <= {CW{1'b0}};
        end else if (i_en && (r_count != {CW{1'b1}})) begin
            r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign o_count    = r_count;
    assign o_at_limit = (r_count == LIMIT);

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer for the ACDC core: preload, hold in init, run, report done/timeout.
// Define RUN_CTRL_TIMEOUT_EN to build the MAX_CYCLES timeout (TMO state).
module run_ctrl
    import acdc_pkg::*;
#(
    parameter int            AW           = AW_DEF,
    parameter int            DW           = DW_DEF,
    parameter int            CW           = CW_DEF,
    parameter int            START_CYCLES = START_CYCLES_DEF,
    parameter logic [CW-1:0] MAX_CYCLES   = 16'hFFFE
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          go,
    input  logic          skip_load,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          dut_start,
    input  logic          dut_halt,
    output logic          busy,
    output logic          done,
    output logic          timed_out,
    output logic [CW-1:0] cycle_count
);

    localparam logic [3:0] START_LD = 4'(START_CYCLES - 1);

`ifdef RUN_CTRL_TIMEOUT_EN
    localparam logic [CW-1:0] CNT_LIMIT = MAX_CYCLES;
`else
    // Without the timeout the limit collapses onto the saturation point.
    localparam logic [CW-1:0] CNT_LIMIT = MAX_CYCLES | {CW{1'b1}};
`endif

    run_state_t    r_state;
    logic [3:0]    r_start_cnt;
    logic          r_first_run;
    logic          r_dut_start;
    logic          r_busy;
    logic          r_done;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_din;
`ifdef RUN_CTRL_TIMEOUT_EN
    logic          r_tmo;
`endif

    logic          w_beat;
    logic          w_go;
    logic          w_halt_q;
    logic          w_cnt_clr;
    logic          w_cnt_en;
    logic          w_at_limit;
    logic [CW-1:0] w_count;

    assign w_beat    = (r_state == RS_LOAD) && load_valid;
    assign w_go      = go && accepts_go(r_state);
    // Halt coming out of init is stale, so the first RUN cycle ignores it.
    assign w_halt_q  = dut_halt && !r_first_run;
    assign w_cnt_clr = (w_go && skip_load) || (w_beat && load_last);
    assign w_cnt_en  = (r_state == RS_RUN) && !w_halt_q && !w_at_limit;

    run_counter #(
        .CW    (CW),
        .LIMIT (CNT_LIMIT)
    ) u_run_counter (
        .i_clk      (CLK),
        .i_rst_n    (reset_n),
        .i_clr      (w_cnt_clr),
        .i_en       (w_cnt_en),
        .o_count    (w_count),
        .o_at_limit (w_at_limit)
    );

    // Sequencer state and all registered outputs.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_state     <= RS_IDLE;
            r_start_cnt <= 4'd0;
            r_first_run <= 1'b0;
            r_dut_start <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {AW{1'b0}};
            r_mem_din   <= {DW{1'b0}};
`ifdef RUN_CTRL_TIMEOUT_EN
            r_tmo       <= 1'b0;
`endif
        end else begin
            r_mem_we    <= 1'b0;
            r_first_run <= 1'b0;
            case (r_state)
                RS_IDLE, RS_DONE, RS_TMO: begin
                    if (w_go) begin
                        r_done <= 1'b0;
`ifdef RUN_CTRL_TIMEOUT_EN
                        r_tmo  <= 1'b0;
`endif
                        r_busy <= 1'b1;
                        if (skip_load) begin
                            r_state     <= RS_START;
                            r_start_cnt <= START_LD;
                        end else begin
                            r_state <= RS_LOAD;
                        end
                    end
                end
                RS_LOAD: begin
                    if (w_beat) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= load_addr;
                        r_mem_din  <= load_data;
                        if (load_last) begin
                            r_state     <= RS_START;
                            r_start_cnt <= START_LD;
                        end
                    end
                end
                RS_START: begin
                    if (r_start_cnt == 4'd0) begin
                        r_state     <= RS_RUN;
                        r_dut_start <= 1'b0;
                        r_first_run <= 1'b1;
                    end else begin
                        r_start_cnt <= r_start_cnt - 4'd1;
                    end
                end
                RS_RUN: begin
                    if (w_halt_q) begin
                        r_state     <= RS_DONE;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_dut_start <= 1'b1;
                    end
`ifdef RUN_CTRL_TIMEOUT_EN
                    else if (w_at_limit) begin
                        r_state     <= RS_TMO;
                        r_tmo       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_dut_start <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state     <= RS_IDLE;
                    r_busy      <= 1'b0;
                    r_dut_start <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready  = (r_state == RS_LOAD);
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_din     = r_mem_din;
    assign dut_start   = r_dut_start;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cycle_count = w_count;
`ifdef RUN_CTRL_TIMEOUT_EN
    assign timed_out   = r_tmo;
`else
    assign timed_out   = 1'b0;
`endif

endmodule
